bcd_sign_encoder: RTL

//   Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding the 8-digit
//   7-seg display driver. Latches a binary value on start and emits eight 4-bit digit codes

---
 rtl/bcd_sign_encoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bcd_sign_encoder.sv
// Shift-add-3 binary-to-BCD converter driving eight 7-seg digit codes.
// Optional BCD_OVF_ERR_EN: overflow shows "000000EE" instead of saturating to 99999999.
module bcd_sign_encoder #(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             en,
  output logic [3:0]       sign7,
  output logic [3:0]       sign6,
  output logic [3:0]       sign5,
  output logic [3:0]       sign4,
  output logic [3:0]       sign3,
  output logic [3:0]       sign2,
  output logic [3:0]       sign1,
  output logic [3:0]       sign0
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  localparam logic [26:0] MAX_DEC = 27'd99999999;
  localparam logic [4:0]  LAST    = 5'(WIDTH - 1);

`ifdef BCD_OVF_ERR_EN
  localparam logic [31:0] OVF_CODE = 32'h0000_00EE;
`else
  localparam logic [31:0] OVF_CODE = 32'h9999_9999;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [31:0]      bcd_q, bcd_d;
  logic [31:0]      bcd_adj;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      sign_q, sign_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic [26:0]      value_ext;

  assign value_ext = 27'(value);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    sign_d   = sign_q;
    en_d     = en_q;
    done_d   = 1'b0;
    bcd_adj  = bcd_q;

    for (int i = 0; i < 8; i++) begin
      if (bcd_adj[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = value;
          bcd_d    = '0;
          cnt_d    = '0;
          ovf_d    = value_ext > MAX_DEC;
          state_d  = CONV;
        end
      end
      CONV: begin
        // Adjusted BCD and shadow shift as one register; BCD MSB falls off.
        {bcd_d, shadow_d} = {bcd_adj, shadow_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        sign_d  = ovf_q ? OVF_CODE : bcd_q;
        en_d    = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      sign_q   <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sign_q   <= sign_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  assign busy  = state_q != IDLE;
  assign done  = done_q;
  assign en    = en_q;
  assign sign7 = sign_q[31:28];
  assign sign6 = sign_q[27:24];
  assign sign5 = sign_q[23:20];
  assign sign4 = sign_q[19:16];
  assign sign3 = sign_q[15:12];
  assign sign2 = sign_q[11:8];
  assign sign1 = sign_q[7:4];
  assign sign0 = sign_q[3:0];

endmodule
